// File: rtl/ofdm_rx_pkg.sv
// Shared constants and types for the OFDM receive chain.
// Holds the symbol geometry, the sample width and the cyclic-prefix remover state encoding.
package ofdm_rx_pkg;

  localparam int N_FFT = 64;
  localparam int N_CP  = 16;
  localparam int IQ_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    CP,
    DATA
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/Delay_reg.sv
// Enabled one-stage delay register with synchronous active-low clear.
// Captures d only when en is high, otherwise q holds its last value.
module Delay_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cp_remover.sv
// Cyclic-prefix remover: drops N_CP prefix samples of each OFDM symbol and forwards
// the N_FFT useful samples with sop/eop framing, symbol index and packet done/abort.
module cp_remover #(
  parameter int WIDTH = ofdm_rx_pkg::IQ_W,
  parameter int N_FFT = ofdm_rx_pkg::N_FFT,
  parameter int N_CP  = ofdm_rx_pkg::N_CP,
  parameter int SYM_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_start,
  input  logic [SYM_W-1:0] pkt_len,
  input  logic             in_ena,
  input  logic [WIDTH-1:0] dat_in,
  output logic             out_ena,
  output logic [WIDTH-1:0] dat_out,
  output logic             out_sop,
  output logic             out_eop,
  output logic [SYM_W-1:0] sym_idx,
  output logic             busy,
  output logic             done,
  output logic             abort
);

  import ofdm_rx_pkg::*;

  localparam int CP_W  = (N_CP > 1) ? clog2(N_CP) : 1;
  localparam int DAT_W = (N_FFT > 1) ? clog2(N_FFT) : 1;
  localparam logic [CP_W-1:0]  CP_LAST  = CP_W'(N_CP - 1);
  localparam logic [DAT_W-1:0] DAT_LAST = DAT_W'(N_FFT - 1);
  localparam logic [SYM_W-1:0] SYM_ONE  = SYM_W'(1);

  state_t             state, state_n;
  logic [CP_W-1:0]    cp_cnt, cp_n;
  logic [DAT_W-1:0]   dat_cnt, dat_n;
  logic [SYM_W-1:0]   sym_cnt, sym_n;
  logic [SYM_W-1:0]   len, len_n;
  logic               start;
  logic               fwd;
  logic               last;

  // Streaming input has no backpressure: a sample is accepted on every cycle with
  // in_ena=1, and every accepted DATA sample is presented exactly one clock later.
  assign start = in_ena & pkt_start & (pkt_len != '0);

  always_comb begin
    state_n = state;
    cp_n    = cp_cnt;
    dat_n   = dat_cnt;
    sym_n   = sym_cnt;
    len_n   = len;
    fwd     = 1'b0;
    last    = 1'b0;
    if (start) begin
      // A new packet always wins, including over the final sample of the current one.
      len_n   = pkt_len;
      sym_n   = '0;
      dat_n   = '0;
      cp_n    = CP_W'(1);
      state_n = (N_CP == 1) ? DATA : CP;
    end else if (in_ena) begin
      unique case (state)
        CP: begin
          if (cp_cnt == CP_LAST) begin
            state_n = DATA;
            dat_n   = '0;
          end else begin
            cp_n = cp_cnt + CP_W'(1);
          end
        end
        DATA: begin
          fwd = 1'b1;
          if (dat_cnt == DAT_LAST) begin
            if (sym_cnt == len - SYM_ONE) begin
              last    = 1'b1;
              state_n = IDLE;
            end else begin
              sym_n   = sym_cnt + SYM_ONE;
              cp_n    = '0;
              state_n = CP;
            end
          end else begin
            dat_n = dat_cnt + DAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cp_cnt  <= '0;
      dat_cnt <= '0;
      sym_cnt <= '0;
      len     <= '0;
      out_ena <= 1'b0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      sym_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      state   <= state_n;
      cp_cnt  <= cp_n;
      dat_cnt <= dat_n;
      sym_cnt <= sym_n;
      len     <= len_n;
      out_ena <= fwd;
      out_sop <= fwd & (dat_cnt == '0);
      out_eop <= fwd & (dat_cnt == DAT_LAST);
      done    <= last;
      abort   <= start & (state != IDLE);
      // busy trails the state by one clock so it stays high alongside the final done.
      busy    <= start | (state != IDLE);
      if (fwd) sym_idx <= sym_cnt;
    end
  end

  Delay_reg #(
    .WIDTH (WIDTH)
  ) u_dat_dly (
    .clk (clk),
    .rst (rst),
    .en  (fwd),
    .d   (dat_in),
    .q   (dat_out)
  );

endmodule

// File: tb/tb_cp_remover.sv
// Self-checking bench for cp_remover: a packet-position model pushes expected outputs
// into a queue as samples are driven, and each DUT output is popped and compared.
module tb_cp_remover;

  localparam int W = 32;
  localparam int SW = 10;
  localparam int SYM_LEN = 80;
  localparam int CPL = 16;

  logic          clk;
  logic          rst;
  logic          pkt_start;
  logic [SW-1:0] pkt_len;
  logic          in_ena;
  logic [W-1:0]  dat_in;
  logic          out_ena;
  logic [W-1:0]  dat_out;
  logic          out_sop;
  logic          out_eop;
  logic [SW-1:0] sym_idx;
  logic          busy;
  logic          done;
  logic          abort;

  cp_remover dut (
    .clk       (clk),
    .rst       (rst),
    .pkt_start (pkt_start),
    .pkt_len   (pkt_len),
    .in_ena    (in_ena),
    .dat_in    (dat_in),
    .out_ena   (out_ena),
    .dat_out   (dat_out),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .sym_idx   (sym_idx),
    .busy      (busy),
    .done      (done),
    .abort     (abort)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: {done, eop, sop, sym_idx, data}
  logic [W+SW+2:0] exp_q[$];
  int n_checks;
  int n_fail;
  bit m_active;
  int m_len;
  int m_idx;
  logic [W-1:0] last_out;
  int out_cnt, eop_cnt, done_cnt, abort_cnt;

  task automatic clear_counts();
    out_cnt = 0;
    eop_cnt = 0;
    done_cnt = 0;
    abort_cnt = 0;
  endtask

  // driver: presents one input cycle, updates the model and checks the resulting outputs
  task automatic drive(input logic st, input logic [SW-1:0] len, input logic ena, input logic [W-1:0] d);
    logic was_active;
    logic exp_ab;
    logic exp_busy;
    logic [W+SW+2:0] e;
    logic [W+SW+2:0] got;
    int pos;
    int sym;
    was_active = m_active;
    exp_ab = 1'b0;
    pkt_start = st;
    pkt_len = len;
    in_ena = ena;
    dat_in = d;
    if (ena && st && len != 0) begin
      exp_ab = m_active;
      m_active = 1'b1;
      m_len = int'(len);
      m_idx = 0;
    end else if (ena && m_active) begin
      m_idx++;
      pos = m_idx % SYM_LEN;
      sym = m_idx / SYM_LEN;
      if (pos >= CPL) begin
        e = {(pos == SYM_LEN - 1) && (sym == m_len - 1), pos == SYM_LEN - 1, pos == CPL, SW'(sym), d};
        exp_q.push_back(e);
        if (e[W+SW+2]) m_active = 1'b0;
      end
    end
    exp_busy = was_active | m_active;
    @(posedge clk);
    #1;
    n_checks++;
    if (abort !== exp_ab) begin
      n_fail++;
      $display("FAIL abort: got %b expected %b at %0t", abort, exp_ab, $time);
    end
    if (abort === 1'b1) abort_cnt++;
    n_checks++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy: got %b expected %b at %0t", busy, exp_busy, $time);
    end
    n_checks++;
    if (out_ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got dat_out %h expected no out_ena at %0t", dat_out, $time);
      end else begin
        e = exp_q.pop_front();
        got = {done, out_eop, out_sop, sym_idx, dat_out};
        if (got !== e) begin
          n_fail++;
          $display("FAIL output: got done/eop/sop/sym/dat %b/%b/%b/%0d/%h expected %b/%b/%b/%0d/%h at %0t",
                   done, out_eop, out_sop, sym_idx, dat_out,
                   e[W+SW+2], e[W+SW+1], e[W+SW], e[W+SW-1:W], e[W-1:0], $time);
        end
      end
      last_out = dat_out;
      out_cnt++;
      if (out_eop === 1'b1) eop_cnt++;
      if (done === 1'b1) done_cnt++;
    end else begin
      if (dat_out !== last_out || {done, out_sop, out_eop} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_output: got dat_out %h done/sop/eop %b%b%b expected %h 000 at %0t",
                 dat_out, done, out_sop, out_eop, last_out, $time);
      end
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_output: got no out_ena expected %0d pending outputs at %0t", exp_q.size(), $time);
      exp_q.delete();
    end
  endtask

  task automatic apply_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst = 1'b0;
      pkt_start = 1'b1;
      pkt_len = 10'd1;
      in_ena = 1'b1;
      dat_in = $urandom;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_ena, out_sop, out_eop, done, abort, busy} !== 6'b0 || dat_out !== '0 || sym_idx !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got ena/sop/eop/done/abort/busy %b%b%b%b%b%b dat %h sym %0d expected all zero",
                 out_ena, out_sop, out_eop, done, abort, busy, dat_out, sym_idx);
      end
    end
    m_active = 1'b0;
    exp_q.delete();
    last_out = '0;
    rst = 1'b1;
    pkt_start = 1'b0;
    in_ena = 1'b0;
  endtask

  task automatic check_counts(input string name, input int e_out, input int e_eop, input int e_done, input int e_abort);
    n_checks++;
    if (out_cnt != e_out || eop_cnt != e_eop || done_cnt != e_done || abort_cnt != e_abort) begin
      n_fail++;
      $display("FAIL %s_counts: got out/eop/done/abort %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
               name, out_cnt, eop_cnt, done_cnt, abort_cnt, e_out, e_eop, e_done, e_abort);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    drive(1'b0, 10'd0, 1'b0, 32'h0);
  endtask

  task automatic test_single_symbol();
    clear_counts();
    for (int i = 0; i < SYM_LEN; i++) drive(i == 0, 10'd1, 1'b1, W'(i));
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || dat_out !== 32'd79) begin
      n_fail++;
      $display("FAIL single_end: got done %b busy %b dat %0d expected 1 1 79", done, busy, dat_out);
    end
    drive(1'b0, 10'd0, 1'b0, 32'hdead_beef);
    check_counts("single", 64, 1, 1, 0);
  endtask

  task automatic test_gaps();
    clear_counts();
    for (int i = 0; i < 3 * SYM_LEN; i++) begin
      drive(i == 0, 10'd3, 1'b1, W'(i));
      drive(1'b0, 10'd0, 1'b0, $urandom);
    end
    check_counts("gaps", 192, 3, 1, 0);
  endtask

  task automatic test_restart();
    clear_counts();
    for (int i = 0; i < CPL + 30; i++) drive(i == 0, 10'd2, 1'b1, W'(i));
    drive(1'b1, 10'd1, 1'b1, 32'd1000);
    for (int i = 1; i < SYM_LEN; i++) drive(1'b0, 10'd0, 1'b1, W'(1000 + i));
    drive(1'b0, 10'd0, 1'b0, 32'h0);
    check_counts("restart", 30 + 64, 1, 1, 1);
  endtask

  task automatic test_end_restart();
    clear_counts();
    for (int i = 0; i < SYM_LEN - 1; i++) drive(i == 0, 10'd1, 1'b1, W'(i));
    drive(1'b1, 10'd1, 1'b1, 32'd2000);
    for (int i = 1; i < SYM_LEN; i++) drive(1'b0, 10'd0, 1'b1, W'(2000 + i));
    drive(1'b0, 10'd0, 1'b0, 32'h0);
    check_counts("end_restart", 63 + 64, 1, 1, 1);
  endtask

  task automatic test_len_zero();
    clear_counts();
    drive(1'b1, 10'd0, 1'b1, 32'd5);
    for (int i = 0; i < 100; i++) drive(1'b0, 10'd0, 1'b1, W'(i));
    check_counts("len_zero", 0, 0, 0, 0);
  endtask

  task automatic test_start_no_ena();
    clear_counts();
    drive(1'b1, 10'd1, 1'b0, 32'd5);
    for (int i = 0; i < 100; i++) drive(1'b0, 10'd0, 1'b1, W'(i));
    check_counts("start_no_ena", 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    clear_counts();
    for (int i = 0; i < 2 * SYM_LEN + 5; i++) drive(i == 0, 10'd3, 1'b1, W'(i));
    apply_reset(1);
    for (int i = 0; i < 100; i++) drive(1'b0, 10'd0, 1'b1, W'(i));
    check_counts("reset_mid", 128, 2, 0, 0);
  endtask

  task automatic test_random();
    int len;
    int acc;
    int guard;
    clear_counts();
    len = $urandom_range(1, 4);
    acc = 0;
    guard = 0;
    while (acc < len * SYM_LEN && guard < 4000) begin
      if ($urandom_range(0, 2) != 0) begin
        drive(acc == 0, SW'(len), 1'b1, $urandom);
        acc++;
      end else begin
        drive(1'b0, 10'd0, 1'b0, $urandom);
      end
      guard++;
    end
    drive(1'b0, 10'd0, 1'b0, 32'h0);
    check_counts("random", len * 64, len, 1, 0);
  endtask

  initial begin
    rst = 1'b0;
    pkt_start = 1'b0;
    pkt_len = '0;
    in_ena = 1'b0;
    dat_in = '0;
    n_checks = 0;
    n_fail = 0;
    m_active = 1'b0;
    m_len = 0;
    m_idx = 0;
    last_out = '0;
    clear_counts();
    test_reset();
    test_single_symbol();
    test_gaps();
    test_restart();
    test_end_restart();
    test_len_zero();
    test_start_no_ena();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
